// File: rtl/sc_mult_sequencer.sv
// Moore control sequencer that multiplies FIXED0 x FIXED1 into R0 by repeated
// addition on an external register/ALU datapath, then loads R0 into the shifter.
module sc_mult_sequencer #(
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
) (
  input  logic                                      SC_MULTSEQUENCER_CLOCK_50,
  input  logic                                      SC_MULTSEQUENCER_Reset_InHigh,
  input  logic                                      SC_MULTSEQUENCER_Start_InHigh,
  input  logic                                      SC_MULTSEQUENCER_Zero_InLow,
  input  logic                                      SC_MULTSEQUENCER_Carry_InLow,
  input  logic                                      SC_MULTSEQUENCER_Overflow_InLow,
  input  logic                                      SC_MULTSEQUENCER_Negative_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_MULTSEQUENCER_DecoderSelectionWrite_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_MULTSEQUENCER_MUXSelectionBUSA_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_MULTSEQUENCER_MUXSelectionBUSB_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_MULTSEQUENCER_ALUSelection_Out,
  output logic                                      SC_MULTSEQUENCER_RegSHIFTERLoad_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_MULTSEQUENCER_RegSHIFTERShiftSelection_OutLow,
  output logic                                      SC_MULTSEQUENCER_Busy_Out,
  output logic                                      SC_MULTSEQUENCER_Done_Out,
  output logic                                      SC_MULTSEQUENCER_Error_Out
);

  localparam int DW = DATAWIDTH_DECODER_SELECTION;
  localparam int MW = DATAWIDTH_MUX_SELECTION;
  localparam int AW = DATAWIDTH_ALU_SELECTION;

  localparam logic [DW-1:0] DEC_R0   = DW'(0);
  localparam logic [DW-1:0] DEC_R1   = DW'(1);
  localparam logic [DW-1:0] DEC_NONE = DW'(7);

  localparam logic [MW-1:0] MUX_R0     = MW'(0);
  localparam logic [MW-1:0] MUX_R1     = MW'(1);
  localparam logic [MW-1:0] MUX_FIXED0 = MW'(4);
  localparam logic [MW-1:0] MUX_FIXED1 = MW'(5);

  localparam logic [AW-1:0] ALU_PASSA = AW'(0);
  localparam logic [AW-1:0] ALU_ADD   = AW'(1);
  localparam logic [AW-1:0] ALU_SUB   = AW'(2);
  localparam logic [AW-1:0] ALU_DECA  = AW'(3);

  typedef enum logic [2:0] {
    IDLE, CLR, LDCNT, CHK, ADD, DEC, LOAD, DONE
  } stateT;

  typedef struct packed {
    logic [DW-1:0] dec;
    logic [MW-1:0] muxA;
    logic [MW-1:0] muxB;
    logic [AW-1:0] alu;
    logic          loadN;
    logic          busy;
    logic          done;
  } ctrlT;

  stateT state;
  ctrlT  ctrlReg;
  logic  errorReg;
  logic  unusedFlags;

  // Control word for a given state; registered together with the state so the
  // outputs are a pure function of the current state but glitch-free.
  function automatic ctrlT ctrlFor(input stateT s);
    ctrlT c;
    c.dec   = DEC_NONE;
    c.muxA  = MUX_R0;
    c.muxB  = MUX_R0;
    c.alu   = ALU_PASSA;
    c.loadN = 1'b1;
    c.busy  = 1'b0;
    c.done  = 1'b0;
    case (s)
      CLR: begin
        c.muxA = MUX_FIXED0; c.muxB = MUX_FIXED0; c.alu = ALU_SUB;
        c.dec  = DEC_R0;     c.busy = 1'b1;
      end
      LDCNT: begin
        c.muxA = MUX_FIXED1; c.dec = DEC_R1; c.busy = 1'b1;
      end
      CHK: begin
        c.muxA = MUX_R1; c.busy = 1'b1;
      end
      ADD: begin
        c.muxA = MUX_R0; c.muxB = MUX_FIXED0; c.alu = ALU_ADD;
        c.dec  = DEC_R0; c.busy = 1'b1;
      end
      DEC: begin
        c.muxA = MUX_R1; c.alu = ALU_DECA; c.dec = DEC_R1; c.busy = 1'b1;
      end
      LOAD: begin
        c.muxA = MUX_R0; c.loadN = 1'b0; c.busy = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_ff @(posedge SC_MULTSEQUENCER_CLOCK_50 or posedge SC_MULTSEQUENCER_Reset_InHigh) begin
    if (SC_MULTSEQUENCER_Reset_InHigh) begin
      state    <= IDLE;
      ctrlReg  <= ctrlFor(IDLE);
      errorReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (SC_MULTSEQUENCER_Start_InHigh) begin
            state    <= CLR;
            ctrlReg  <= ctrlFor(CLR);
            errorReg <= 1'b0;
          end
        end
        CLR: begin
          state   <= LDCNT;
          ctrlReg <= ctrlFor(LDCNT);
        end
        LDCNT: begin
          state   <= CHK;
          ctrlReg <= ctrlFor(CHK);
        end
        CHK: begin
          if (!SC_MULTSEQUENCER_Zero_InLow) begin
            state   <= LOAD;
            ctrlReg <= ctrlFor(LOAD);
          end else begin
            state   <= ADD;
            ctrlReg <= ctrlFor(ADD);
          end
        end
        ADD: begin
          // Carry out of the accumulate means the product no longer fits in R0.
          if (!SC_MULTSEQUENCER_Carry_InLow) begin
            state    <= LOAD;
            ctrlReg  <= ctrlFor(LOAD);
            errorReg <= 1'b1;
          end else begin
            state   <= DEC;
            ctrlReg <= ctrlFor(DEC);
          end
        end
        DEC: begin
          if (!SC_MULTSEQUENCER_Zero_InLow) begin
            state   <= LOAD;
            ctrlReg <= ctrlFor(LOAD);
          end else begin
            state   <= ADD;
            ctrlReg <= ctrlFor(ADD);
          end
        end
        LOAD: begin
          state   <= DONE;
          ctrlReg <= ctrlFor(DONE);
        end
        DONE: begin
          if (!SC_MULTSEQUENCER_Start_InHigh) begin
            state   <= IDLE;
            ctrlReg <= ctrlFor(IDLE);
          end
        end
        default: begin
          state   <= IDLE;
          ctrlReg <= ctrlFor(IDLE);
        end
      endcase
    end
  end

  assign SC_MULTSEQUENCER_DecoderSelectionWrite_Out       = ctrlReg.dec;
  assign SC_MULTSEQUENCER_MUXSelectionBUSA_Out            = ctrlReg.muxA;
  assign SC_MULTSEQUENCER_MUXSelectionBUSB_Out            = ctrlReg.muxB;
  assign SC_MULTSEQUENCER_ALUSelection_Out                = ctrlReg.alu;
  assign SC_MULTSEQUENCER_RegSHIFTERLoad_OutLow           = ctrlReg.loadN;
  assign SC_MULTSEQUENCER_RegSHIFTERShiftSelection_OutLow = '0;
  assign SC_MULTSEQUENCER_Busy_Out                        = ctrlReg.busy;
  assign SC_MULTSEQUENCER_Done_Out                        = ctrlReg.done;
  assign SC_MULTSEQUENCER_Error_Out                       = errorReg;

  // Overflow and negative flags play no part in sequencing.
  assign unusedFlags = SC_MULTSEQUENCER_Overflow_InLow ^ SC_MULTSEQUENCER_Negative_InLow;

endmodule

// File: tb/tb_sc_mult_sequencer.sv
// Bench for sc_mult_sequencer: drives an 8-bit register/ALU/shifter model from
// the sequencer outputs and scores product, error, latency and ADD count per run.
module tb_sc_mult_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       zeroN, carryN;
  logic       ovfN = 1'b1;
  logic       negN = 1'b1;
  logic [2:0] dec, muxA, muxB;
  logic [3:0] alu;
  logic       loadN, busy, done, err;
  logic [1:0] shiftSel;

  int checks = 0;
  int failures = 0;

  logic [7:0] regs [0:3] = '{default: 8'd0};
  logic [7:0] fixed0 = 8'd0;
  logic [7:0] fixed1 = 8'd0;
  logic [7:0] shifterReg = 8'd0;
  logic [7:0] busA, busB, aluRes;
  logic       aluCarry;
  int addCount = 0;
  int loadCount = 0;

  typedef struct {
    int product;
    int err;
    int latency;
    int adds;
  } expT;
  expT sb[$];

  sc_mult_sequencer dut (
    .SC_MULTSEQUENCER_CLOCK_50                        (clk),
    .SC_MULTSEQUENCER_Reset_InHigh                    (rst),
    .SC_MULTSEQUENCER_Start_InHigh                    (start),
    .SC_MULTSEQUENCER_Zero_InLow                      (zeroN),
    .SC_MULTSEQUENCER_Carry_InLow                     (carryN),
    .SC_MULTSEQUENCER_Overflow_InLow                  (ovfN),
    .SC_MULTSEQUENCER_Negative_InLow                  (negN),
    .SC_MULTSEQUENCER_DecoderSelectionWrite_Out       (dec),
    .SC_MULTSEQUENCER_MUXSelectionBUSA_Out            (muxA),
    .SC_MULTSEQUENCER_MUXSelectionBUSB_Out            (muxB),
    .SC_MULTSEQUENCER_ALUSelection_Out                (alu),
    .SC_MULTSEQUENCER_RegSHIFTERLoad_OutLow           (loadN),
    .SC_MULTSEQUENCER_RegSHIFTERShiftSelection_OutLow (shiftSel),
    .SC_MULTSEQUENCER_Busy_Out                        (busy),
    .SC_MULTSEQUENCER_Done_Out                        (done),
    .SC_MULTSEQUENCER_Error_Out                       (err)
  );

  always #5 clk = ~clk;

  // Datapath model: bus muxes, ALU with active-low flags, registers, shifter.
  always_comb begin
    if (muxA < 3'd4)       busA = regs[muxA[1:0]];
    else if (muxA == 3'd4) busA = fixed0;
    else if (muxA == 3'd5) busA = fixed1;
    else                   busA = 8'd0;
    if (muxB < 3'd4)       busB = regs[muxB[1:0]];
    else if (muxB == 3'd4) busB = fixed0;
    else if (muxB == 3'd5) busB = fixed1;
    else                   busB = 8'd0;
    {aluCarry, aluRes} = {1'b0, busA};
    case (alu)
      4'd1:    {aluCarry, aluRes} = {1'b0, busA} + {1'b0, busB};
      4'd2:    {aluCarry, aluRes} = {1'b0, busA} - {1'b0, busB};
      4'd3:    {aluCarry, aluRes} = {1'b0, busA} - 9'd1;
      default: ;
    endcase
  end

  assign zeroN  = (aluRes != 8'd0);
  assign carryN = ~aluCarry;

  always @(posedge clk) begin
    if (dec < 3'd4) regs[dec[1:0]] <= aluRes;
    if (!loadN) shifterReg <= aluRes;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Every cycle: legal write selects, shifter load only in the LOAD drive pattern.
  always @(negedge clk) begin
    check("dec_legal", {31'd0, (dec == 3'd0 || dec == 3'd1 || dec == 3'd7)}, 32'd1);
    check("load_only_in_load",
          {31'd0, (loadN || (busy && alu == 4'd0 && muxA == 3'd0 && dec == 3'd7))}, 32'd1);
    check("shift_hold", {30'd0, shiftSel}, 32'd0);
    if (alu == 4'd1) addCount++;
    if (!loadN) loadCount++;
  end

  function automatic expT computeExp(input int f0, input int f1);
    expT e;
    int r0;
    int s;
    r0 = 0;
    e.err = 0;
    e.adds = 0;
    e.latency = 4 + 2 * f1;
    for (int k = 1; k <= f1; k++) begin
      e.adds = k;
      s = r0 + f0;
      r0 = s % 256;
      if (s > 255) begin
        e.err = 1;
        e.latency = 2 * k + 3;
        break;
      end
    end
    e.product = r0;
    return e;
  endfunction

  task automatic runOp(input int f0, input int f1, input bit hold);
    expT e;
    int cycles;
    fixed0 = f0[7:0];
    fixed1 = f1[7:0];
    sb.push_back(computeExp(f0, f1));
    @(negedge clk);
    addCount = 0;
    loadCount = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("error_cleared_in_clr", {31'd0, err}, 32'd0);
    if (!hold) start = 1'b0;
    cycles = 0;
    while (!done && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    e = sb.pop_front();
    check("latency", cycles, e.latency);
    check("product", {24'd0, shifterReg}, e.product);
    check("error", {31'd0, err}, e.err);
    check("add_count", addCount, e.adds);
    check("load_once", loadCount, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    $display("op %0d x %0d -> product=%0d error=%0b latency=%0d adds=%0d",
             f0, f1, shifterReg, err, cycles, addCount);
    if (!hold) begin
      @(posedge clk);
      #1;
      check("done_falls", {31'd0, done}, 32'd0);
    end
  endtask

  task automatic checkIdleOutputs(input string phase);
    check({phase, "_dec"},   {29'd0, dec},   32'd7);
    check({phase, "_muxA"},  {29'd0, muxA},  32'd0);
    check({phase, "_muxB"},  {29'd0, muxB},  32'd0);
    check({phase, "_alu"},   {28'd0, alu},   32'd0);
    check({phase, "_loadN"}, {31'd0, loadN}, 32'd1);
    check({phase, "_busy"},  {31'd0, busy},  32'd0);
    check({phase, "_done"},  {31'd0, done},  32'd0);
    check({phase, "_error"}, {31'd0, err},   32'd0);
  endtask

  initial begin
    // Asynchronous reset with no clock edge in between.
    #1 rst = 1'b1;
    #1 checkIdleOutputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("idle_without_start", {31'd0, busy}, 32'd0);

    runOp(9, 15, 1'b0);
    runOp(5, 0, 1'b0);
    runOp(200, 2, 1'b0);
    check("error_sticky_idle", {31'd0, err}, 32'd1);
    runOp(3, 4, 1'b0);

    // Reset in the middle of the ADD/DEC loop.
    fixed0 = 8'd7;
    fixed1 = 8'd10;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 20 && alu != 4'd3; i++) begin
      @(posedge clk);
      #1;
    end
    check("reached_dec", {28'd0, alu}, 32'd3);
    #2 rst = 1'b1;
    #1 checkIdleOutputs("midop_reset");
    @(negedge clk);
    rst = 1'b0;
    runOp(7, 10, 1'b0);

    // Start held through DONE after an overflow, then a single fresh run.
    runOp(100, 3, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("done_held", {31'd0, done}, 32'd1);
    check("no_restart", {31'd0, busy}, 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1 check("done_falls_after_hold", {31'd0, done}, 32'd0);
    check("error_sticky_before_rerun", {31'd0, err}, 32'd1);
    runOp(11, 11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_mult_sequencer.md
SC_MULT_SEQUENCER -- requirements
Module: sc_mult_sequencer

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
 - DATAWIDTH_DECODER_SELECTION, 3, decoder write-select width.
 - DATAWIDTH_MUX_SELECTION, 3, bus A/B mux select width.
 - DATAWIDTH_ALU_SELECTION, 4, ALU op select width.
 - DATAWIDTH_REGSHIFTER_SELECTION, 2, shifter mode width.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
 - SC_MULTSEQUENCER_CLOCK_50, in, 1, the only clock; all state changes on its rising edge.
 - SC_MULTSEQUENCER_Reset_InHigh, in, 1, asynchronous active-high reset.
 - SC_MULTSEQUENCER_Start_InHigh, in, 1, multiply request, level.
 - SC_MULTSEQUENCER_Zero_InLow, in, 1, ALU zero flag, 0 = result zero.
 - SC_MULTSEQUENCER_Carry_InLow, in, 1, ALU carry flag, 0 = carry out.
 - SC_MULTSEQUENCER_Overflow_InLow, in, 1, ALU overflow flag; not used for control.
 - SC_MULTSEQUENCER_Negative_InLow, in, 1, ALU negative flag; not used for control.
 - SC_MULTSEQUENCER_DecoderSelectionWrite_Out, out, DEC width, register write select; 0-3 write R0-R3, 7 = no write.
 - SC_MULTSEQUENCER_MUXSelectionBUSA_Out, out, MUX width, bus A source; 0-3 = R0-R3, 4 = FIXED0, 5 = FIXED1.
 - SC_MULTSEQUENCER_MUXSelectionBUSB_Out, out, MUX width, bus B source; same encoding.
 - SC_MULTSEQUENCER_ALUSelection_Out, out, ALU width, 0000 PASSA, 0001 ADD, 0010 SUB, 0011 DECA.
 - SC_MULTSEQUENCER_RegSHIFTERLoad_OutLow, out, 1, 0 = shifter loads bus C.
 - SC_MULTSEQUENCER_RegSHIFTERShiftSelection_OutLow, out, 2, 00 = hold; the block drives only 00.
 - SC_MULTSEQUENCER_Busy_Out, out, 1, operation in progress.
 - SC_MULTSEQUENCER_Done_Out, out, 1, result loaded into the shifter.
 - SC_MULTSEQUENCER_Error_Out, out, 1, sticky product overflow.

Function
REQ-003 The block SHALL compute R0 = FIXED0 x FIXED1 by repeated addition, with R1 as the down-counter, and SHALL load R0 into the shifter for display.
REQ-004 The FSM SHALL be Moore with states IDLE, CLR, LDCNT, CHK, ADD, DEC, LOAD, DONE; outputs SHALL be decoded from the registered state only.
REQ-005 Flags SHALL be sampled at the clock edge that ends the state driving the ALU op.
REQ-006 IDLE SHALL drive decoder 7, mux A 0, mux B 0, ALU PASSA, load 1, shift 00, Busy 0.
 - Transitions: Start=1 -> CLR; otherwise stay in IDLE.
REQ-007 CLR SHALL drive A=4, B=4, SUB, decoder 0 (R0 <- 0), clear Error, then go to LDCNT.
REQ-008 LDCNT SHALL drive A=5, PASSA, decoder 1 (R1 <- FIXED1), then go to CHK.
REQ-009 CHK SHALL drive A=1, PASSA, decoder 7.
 - Transitions: Zero_InLow=0 -> LOAD (multiplier zero); else ADD.
REQ-010 ADD SHALL drive A=0, B=4, ADD, decoder 0.
 - Transitions: Carry_InLow=0 -> set Error, go to LOAD; else DEC.
REQ-011 DEC SHALL drive A=1, DECA, decoder 1.
 - Transitions: Zero_InLow=0 -> LOAD; else ADD.
REQ-012 LOAD SHALL drive A=0, PASSA, decoder 7, load 0 for exactly one cycle, then go to DONE.
REQ-013 DONE SHALL hold Done=1 with the IDLE datapath drive.
 - Transitions: Start=0 -> IDLE (Done falls on the same edge); Start held 1 -> stay in DONE, no restart.
REQ-014 Busy SHALL be 1 in CLR through LOAD, and 0 in IDLE and DONE.
REQ-015 At most one register write SHALL occur per cycle; decoder SHALL be 7 in every state not listed as writing.
REQ-016 Start changes while Busy=1 SHALL be ignored; the operation completes.
REQ-017 Latency from Start sampled in IDLE to Done=1 SHALL be 4 + 2*FIXED1 cycles without overflow, and 4 cycles when FIXED1=0.
REQ-018 Error SHALL stay 1 until the next CLR or reset; after an overflow the partial R0 is still loaded.
REQ-019 An unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-020 Reset_InHigh=1 SHALL immediately, without a clock, force IDLE and the REQ-006 outputs with Done=0 and Error=0, including mid-operation.
REQ-021 After reset is released, the first transition out of IDLE SHALL occur on the first edge at which Start=1 is sampled.

Verification
REQ-022 FIXED0=9, FIXED1=15, Start pulse -> 15 ADD/DEC pairs, load=0 once with bus A=R0, Done=1 at cycle 34, Error=0; the system model shows 135.
REQ-023 FIXED1=0 -> path CLR, LDCNT, CHK, LOAD; Done at cycle 4; no ADD state entered.
REQ-024 FIXED0=200, FIXED1=2 -> carry on the second ADD -> Error=1, LOAD, Done; Error clears at the next CLR.
REQ-025 Reset asserted in DEC mid-loop -> asynchronous return to IDLE outputs; a new Start yields the full correct product.
REQ-026 Start held high through DONE -> no restart; Start dropped then raised -> exactly one new run, Error cleared.
REQ-027 Every cycle, a checker verifies decoder is in {0,1,7} and load=0 only in LOAD.
